// File: rtl/add32_vector_engine.sv
// Self-test engine for a 32-bit adder: streams LFSR operand pairs, compares the
// returned sums against a latency-matched expected pipeline and reports errors.
module add32_vector_engine #(
    parameter int unsigned DUT_LAT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] num_vectors,
    input  logic [31:0] seed,
    output logic [31:0] num_1,
    output logic [31:0] num_2,
    input  logic [31:0] o_add_32,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] first_err_idx
);
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 16;
    localparam int unsigned PL = (DUT_LAT == 0) ? 1 : DUT_LAT;
    localparam logic [W-1:0]  LFSR_MASK  = 32'h8020_0003;
    localparam logic [W-1:0]  SEED_B_XOR = 32'hA5A5_A5A5;
    localparam logic [CW-1:0] IDX_NONE   = 16'hFFFF;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state, state_nx;

    logic [W-1:0]  lfsr_a, lfsr_b, lfsr_a_d, lfsr_b_d;
    logic [CW-1:0] cnt, cnt_d, n_lat, n_lat_d;
    logic [W-1:0]  num_1_d, num_2_d;
    logic [CW-1:0] err_d, first_d;
    logic          busy_d, done_d, pass_d;

    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] x);
        return x[0] ? ((x >> 1) ^ LFSR_MASK) : (x >> 1);
    endfunction

    // A zero seed would lock the LFSR, so it is forced to one.
    logic [W-1:0] seed_a, seed_b_raw, seed_b;
    assign seed_a     = (seed == '0) ? W'(1) : seed;
    assign seed_b_raw = seed ^ SEED_B_XOR;
    assign seed_b     = (seed_b_raw == '0) ? W'(1) : seed_b_raw;

    logic start_ok;
    assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));

    // Issue side: the vector on num_1/num_2 in this cycle.
    logic          iss_valid, iss_last;
    logic [W-1:0]  iss_exp;
    assign iss_valid = (state == S_RUN);
    assign iss_last  = (cnt == (n_lat - CW'(1)));
    assign iss_exp   = num_1 + num_2;

    // Expected-sum pipeline, DUT_LAT stages deep (bypassed when zero).
    logic [W-1:0]  exp_pipe  [PL];
    logic [CW-1:0] idx_pipe  [PL];
    logic [PL-1:0] vld_pipe, last_pipe;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            for (int i = 0; i < PL; i++) begin
                exp_pipe[i] <= '0;
                idx_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0]  <= iss_valid;
            last_pipe[0] <= iss_valid && iss_last;
            exp_pipe[0]  <= iss_exp;
            idx_pipe[0]  <= cnt;
            for (int i = 1; i < PL; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
                exp_pipe[i]  <= exp_pipe[i-1];
                idx_pipe[i]  <= idx_pipe[i-1];
            end
        end
    end

    logic          cmp_valid, cmp_last, cmp_err;
    logic [W-1:0]  cmp_exp;
    logic [CW-1:0] cmp_idx;
    assign cmp_valid = (DUT_LAT == 0) ? iss_valid : vld_pipe[PL-1];
    assign cmp_last  = (DUT_LAT == 0) ? (iss_valid && iss_last) : last_pipe[PL-1];
    assign cmp_exp   = (DUT_LAT == 0) ? iss_exp : exp_pipe[PL-1];
    assign cmp_idx   = (DUT_LAT == 0) ? cnt : idx_pipe[PL-1];
    assign cmp_err   = cmp_valid && (o_add_32 != cmp_exp);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nx = (num_vectors == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (iss_last) state_nx = (DUT_LAT == 0) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                if (cmp_valid && cmp_last) state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Next values of all registered outputs and datapath state.
    always_comb begin
        num_1_d  = '0;
        num_2_d  = '0;
        lfsr_a_d = lfsr_a;
        lfsr_b_d = lfsr_b;
        cnt_d    = cnt;
        n_lat_d  = n_lat;
        err_d    = err_count;
        first_d  = first_err_idx;

        if (cmp_err) begin
            if (err_count != IDX_NONE) err_d = err_count + CW'(1);
            if (first_err_idx == IDX_NONE) first_d = cmp_idx;
        end

        if (start_ok) begin
            n_lat_d = num_vectors;
            err_d   = '0;
            first_d = IDX_NONE;
            cnt_d   = '0;
            if (num_vectors != '0) begin
                num_1_d  = seed_a;
                num_2_d  = seed_b;
                lfsr_a_d = lfsr_step(seed_a);
                lfsr_b_d = lfsr_step(seed_b);
            end
        end else if (iss_valid && !iss_last) begin
            num_1_d  = lfsr_a;
            num_2_d  = lfsr_b;
            lfsr_a_d = lfsr_step(lfsr_a);
            lfsr_b_d = lfsr_step(lfsr_b);
            cnt_d    = cnt + CW'(1);
        end

        busy_d = (state_nx == S_RUN) || (state_nx == S_DRAIN);
        done_d = (state_nx == S_DONE);
        pass_d = done_d && (err_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            num_1         <= '0;
            num_2         <= '0;
            lfsr_a        <= '0;
            lfsr_b        <= '0;
            cnt           <= '0;
            n_lat         <= '0;
            err_count     <= '0;
            first_err_idx <= IDX_NONE;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
        end else begin
            num_1         <= num_1_d;
            num_2         <= num_2_d;
            lfsr_a        <= lfsr_a_d;
            lfsr_b        <= lfsr_b_d;
            cnt           <= cnt_d;
            n_lat         <= n_lat_d;
            err_count     <= err_d;
            first_err_idx <= first_d;
            busy          <= busy_d;
            done          <= done_d;
            pass          <= pass_d;
        end
    end
endmodule

// File: tb/tb_add32_vector_engine.sv
// Directed bench for add32_vector_engine: one zero-latency and one two-cycle
// latency instance, each driven by a bench-side adder with optional faults.
module tb_add32_vector_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Instance with DUT_LAT = 0
    logic        reset0 = 1'b1, start0 = 1'b0, wrong0 = 1'b0;
    logic [15:0] nv0 = '0;
    logic [31:0] sd0 = '0;
    logic [31:0] n1_0, n2_0, o0;
    logic        busy0, done0, pass0;
    logic [15:0] err0, fidx0;

    assign o0 = (n1_0 + n2_0) ^ {31'd0, wrong0};

    add32_vector_engine #(.DUT_LAT(0)) dut0 (
        .clk(clk), .reset(reset0), .start(start0), .num_vectors(nv0), .seed(sd0),
        .num_1(n1_0), .num_2(n2_0), .o_add_32(o0), .busy(busy0), .done(done0),
        .pass(pass0), .err_count(err0), .first_err_idx(fidx0)
    );

    // Instance with DUT_LAT = 2, adder modelled as a two-stage pipeline
    logic        reset2 = 1'b1, start2 = 1'b0, fault2 = 1'b0;
    logic [15:0] nv2 = '0;
    logic [31:0] sd2 = '0;
    logic [31:0] n1_2, n2_2, o2, st1, st2;
    logic        busy2, done2, pass2;
    logic [15:0] err2, fidx2, icnt2;

    always @(posedge clk) begin
        if (start2) icnt2 <= '0;
        else if (n1_2 != '0) icnt2 <= icnt2 + 16'd1;
        st1 <= (n1_2 + n2_2) ^ {31'd0, fault2 && (icnt2 == 16'd2 || icnt2 == 16'd5)};
        st2 <= st1;
    end
    assign o2 = st2;

    add32_vector_engine #(.DUT_LAT(2)) dut2 (
        .clk(clk), .reset(reset2), .start(start2), .num_vectors(nv2), .seed(sd2),
        .num_1(n1_2), .num_2(n2_2), .o_add_32(o2), .busy(busy2), .done(done2),
        .pass(pass2), .err_count(err2), .first_err_idx(fidx2)
    );

    task automatic pulse_start0(input logic [15:0] n, input logic [31:0] s);
        @(negedge clk); nv0 = n; sd0 = s; start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
    endtask

    task automatic wait_done0(input int bound);
        for (int i = 0; i < bound && !done0; i++) @(negedge clk);
        tests_run++;
        if (done0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL done0_timeout: done=%b required 1", done0);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({n1_0, n2_0, busy0, done0, pass0, err0, fidx0} !== {64'd0, 3'b000, 16'd0, 16'hFFFF}) begin
            tests_failed++;
            $display("FAIL reset0: n1=%h n2=%h b=%b d=%b p=%b e=%h f=%h required zeros, f=ffff",
                     n1_0, n2_0, busy0, done0, pass0, err0, fidx0);
        end
        tests_run++;
        if ({n1_2, n2_2, busy2, done2, pass2, err2, fidx2} !== {64'd0, 3'b000, 16'd0, 16'hFFFF}) begin
            tests_failed++;
            $display("FAIL reset2: n1=%h n2=%h b=%b d=%b p=%b e=%h f=%h required zeros, f=ffff",
                     n1_2, n2_2, busy2, done2, pass2, err2, fidx2);
        end
        reset0 = 1'b0; reset2 = 1'b0;
    endtask

    task automatic test_clean_run;
        pulse_start0(16'd4, 32'h1);
        tests_run++;
        if ({n1_0, n2_0, o0, busy0} !== {32'h00000001, 32'hA5A5A5A4, 32'hA5A5A5A5, 1'b1}) begin
            tests_failed++;
            $display("FAIL clean_vec0: n1=%h n2=%h sum=%h busy=%b required 00000001 a5a5a5a4 a5a5a5a5 1",
                     n1_0, n2_0, o0, busy0);
        end
        @(negedge clk);
        tests_run++;
        if ({n1_0, n2_0} !== {32'h80200003, 32'h52D2D2D2}) begin
            tests_failed++;
            $display("FAIL clean_vec1: n1=%h n2=%h required 80200003 52d2d2d2", n1_0, n2_0);
        end
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            tests_run++;
            if (done0 !== (k == 4)) begin
                tests_failed++;
                $display("FAIL clean_done_cycle%0d: done=%b required %b", k, done0, k == 4);
            end
        end
        tests_run++;
        if ({pass0, err0, fidx0, busy0, n1_0, n2_0} !== {1'b1, 16'd0, 16'hFFFF, 1'b0, 64'd0}) begin
            tests_failed++;
            $display("FAIL clean_result: pass=%b err=%h first=%h busy=%b n1=%h n2=%h required 1 0000 ffff 0 0 0",
                     pass0, err0, fidx0, busy0, n1_0, n2_0);
        end
    endtask

    task automatic test_fault_inject;
        int busy_cycles = 0;
        fault2 = 1'b1;
        @(negedge clk); nv2 = 16'd8; sd2 = 32'h12345678; start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        for (int i = 0; i < 40 && !done2; i++) begin
            if (busy2) busy_cycles++;
            @(negedge clk);
        end
        tests_run++;
        if (done2 !== 1'b1) begin
            tests_failed++;
            $display("FAIL fault_timeout: done=%b required 1", done2);
        end
        tests_run++;
        if (busy_cycles != 10) begin
            tests_failed++;
            $display("FAIL fault_busy_len: busy cycles=%0d required 10", busy_cycles);
        end
        tests_run++;
        if ({err2, fidx2, pass2} !== {16'd2, 16'd2, 1'b0}) begin
            tests_failed++;
            $display("FAIL fault_result: err=%h first=%h pass=%b required 0002 0002 0", err2, fidx2, pass2);
        end
        fault2 = 1'b0;
    endtask

    task automatic test_n0_seed0;
        pulse_start0(16'd0, 32'hDEADBEEF);
        tests_run++;
        if ({done0, pass0, busy0} !== 3'b110) begin
            tests_failed++;
            $display("FAIL n0_done: done=%b pass=%b busy=%b required 1 1 0", done0, pass0, busy0);
        end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if ({n1_0, n2_0} !== 64'd0) begin
                tests_failed++;
                $display("FAIL n0_operands: n1=%h n2=%h required 0 0", n1_0, n2_0);
            end
            @(negedge clk);
        end
        pulse_start0(16'd2, 32'h0);
        tests_run++;
        if ({n1_0, n2_0} !== {32'h00000001, 32'hA5A5A5A5}) begin
            tests_failed++;
            $display("FAIL seed0_vec0: n1=%h n2=%h required 00000001 a5a5a5a5", n1_0, n2_0);
        end
        wait_done0(10);
    endtask

    task automatic test_reset_midrun;
        pulse_start0(16'd100, 32'h1);
        repeat (2) @(negedge clk);
        reset0 = 1'b1;
        @(negedge clk);
        reset0 = 1'b0;
        tests_run++;
        if ({n1_0, n2_0, busy0, done0, pass0, err0, fidx0} !== {64'd0, 3'b000, 16'd0, 16'hFFFF}) begin
            tests_failed++;
            $display("FAIL midrun_reset: n1=%h n2=%h b=%b d=%b p=%b e=%h f=%h required zeros, f=ffff",
                     n1_0, n2_0, busy0, done0, pass0, err0, fidx0);
        end
        @(negedge clk);
        tests_run++;
        if ({busy0, done0, n1_0} !== {2'b00, 32'd0}) begin
            tests_failed++;
            $display("FAIL midrun_idle: busy=%b done=%b n1=%h required 0 0 0", busy0, done0, n1_0);
        end
        pulse_start0(16'd3, 32'h1);
        tests_run++;
        if ({n1_0, n2_0} !== {32'h00000001, 32'hA5A5A5A4}) begin
            tests_failed++;
            $display("FAIL midrun_restart_vec0: n1=%h n2=%h required 00000001 a5a5a5a4", n1_0, n2_0);
        end
        wait_done0(10);
    endtask

    task automatic test_start_handling;
        int busy_cycles = 0;
        wrong0 = 1'b1;
        pulse_start0(16'd6, 32'h1);
        for (int i = 0; i < 30 && !done0; i++) begin
            if (busy0) busy_cycles++;
            start0 = (i == 1 || i == 3);
            nv0 = 16'd2;
            @(negedge clk);
        end
        start0 = 1'b0;
        tests_run++;
        if (busy_cycles != 6) begin
            tests_failed++;
            $display("FAIL start_ignored_len: busy cycles=%0d required 6", busy_cycles);
        end
        tests_run++;
        if ({done0, err0, fidx0, pass0} !== {1'b1, 16'd6, 16'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL start_ignored_result: done=%b err=%h first=%h pass=%b required 1 0006 0000 0",
                     done0, err0, fidx0, pass0);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if ({done0, err0, fidx0} !== {1'b1, 16'd6, 16'd0}) begin
            tests_failed++;
            $display("FAIL done_hold: done=%b err=%h first=%h required 1 0006 0000", done0, err0, fidx0);
        end
        wrong0 = 1'b0;
        pulse_start0(16'd2, 32'h77);
        tests_run++;
        if ({done0, busy0, err0, fidx0} !== {2'b01, 16'd0, 16'hFFFF}) begin
            tests_failed++;
            $display("FAIL relaunch_clear: done=%b busy=%b err=%h first=%h required 0 1 0000 ffff",
                     done0, busy0, err0, fidx0);
        end
        wait_done0(10);
        tests_run++;
        if (pass0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL relaunch_pass: pass=%b required 1", pass0);
        end
    endtask

    task automatic test_saturation;
        wrong0 = 1'b1;
        pulse_start0(16'hFFFF, 32'hCAFEF00D);
        wait_done0(70000);
        tests_run++;
        if ({err0, fidx0, pass0} !== {16'hFFFF, 16'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL saturation: err=%h first=%h pass=%b required ffff 0000 0", err0, fidx0, pass0);
        end
        wrong0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_fault_inject();
        test_n0_seed0();
        test_reset_midrun();
        test_start_handling();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
